// File: rtl/fetch_arb_pkg.sv
// Shared definitions for the descriptor fetch arbiter: FSM state encoding,
// default geometry and a helper that sizes channel-index fields.
package fetch_arb_pkg;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_LEN_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    ACK  = 2'b10
  } state_t;

  // Width of a channel index; a single channel still needs one bit of id.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fetch_arb_rr_pick.sv
// Combinational winner selection for the fetch arbiter. In round-robin mode
// the search starts just after the previous winner and wraps; in fixed
// priority mode the lowest eligible index wins.
module fetch_arb_rr_pick
  import fetch_arb_pkg::*;
#(
  parameter  int NUM_CH = DEF_NUM_CH,
  localparam int ID_W   = id_width(NUM_CH)
) (
  input  logic [NUM_CH-1:0] eligible,
  input  logic [ID_W-1:0]   last_grant,
  input  logic              prio_mode,
  output logic [ID_W-1:0]   winner,
  output logic              found
);

  logic [ID_W-1:0] idx;

  // Scan from lowest to highest priority so the highest-priority hit is the last write.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    if (prio_mode) begin
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        if (eligible[i]) begin
          winner = ID_W'(i);
          found  = 1'b1;
        end
      end
    end else begin
      for (int k = NUM_CH; k >= 1; k--) begin
        idx = ID_W'((int'(last_grant) + k) % NUM_CH);
        if (eligible[idx]) begin
          winner = idx;
          found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fetch_arbiter.sv
// Descriptor fetch arbiter: grants one of NUM_CH channels access to a shared
// read engine, holds the latched request until the engine acknowledges, then
// pulses a one-cycle completion back to the granted channel.
module fetch_arbiter
  import fetch_arb_pkg::*;
#(
  parameter  int NUM_CH = DEF_NUM_CH,
  parameter  int ADDR_W = DEF_ADDR_W,
  parameter  int LEN_W  = DEF_LEN_W,
  localparam int ID_W   = id_width(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rstb,
  input  logic [NUM_CH-1:0]        ch_fetch_req,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
  input  logic [NUM_CH*LEN_W-1:0]  ch_length,
  output logic [NUM_CH-1:0]        ch_ack,
  input  logic [NUM_CH-1:0]        ch_enable,
  input  logic                     prio_mode,
  output logic                     mem_req,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [LEN_W-1:0]         mem_length,
  output logic [ID_W-1:0]          mem_ch_id,
  input  logic                     mem_ack,
  output logic                     busy,
  output logic                     protocol_err
);

  state_t            state;
  logic [ID_W-1:0]   last_grant;
  logic [NUM_CH-1:0] eligible;
  logic [ID_W-1:0]   winner;
  logic              found;

  assign eligible = ch_fetch_req & ch_enable;

  fetch_arb_rr_pick #(
    .NUM_CH(NUM_CH)
  ) u_pick (
    .eligible  (eligible),
    .last_grant(last_grant),
    .prio_mode (prio_mode),
    .winner    (winner),
    .found     (found)
  );

  // Main FSM: arbitrate in IDLE, hold the request in BUSY, complete in ACK.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state        <= IDLE;
      mem_req      <= 1'b0;
      mem_addr     <= '0;
      mem_length   <= '0;
      mem_ch_id    <= '0;
      ch_ack       <= '0;
      busy         <= 1'b0;
      protocol_err <= 1'b0;
      last_grant   <= ID_W'(NUM_CH - 1);
    end else begin
      ch_ack <= '0;
      if (mem_ack && (state != BUSY)) begin
        protocol_err <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (found) begin
            state      <= BUSY;
            busy       <= 1'b1;
            mem_req    <= 1'b1;
            mem_ch_id  <= winner;
            last_grant <= winner;
            mem_addr   <= ch_addr[int'(winner)*ADDR_W +: ADDR_W];
            mem_length <= ch_length[int'(winner)*LEN_W +: LEN_W];
          end
        end
        BUSY: begin
          if (mem_ack) begin
            state   <= ACK;
            mem_req <= 1'b0;
            ch_ack  <= NUM_CH'(1) << mem_ch_id;
          end
        end
        ACK: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          busy    <= 1'b0;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/fetch_arbiter.md
FETCH_ARBITER -- requirements
Module: fetch_arbiter

Interface
REQ-001 Parameters SHALL be: NUM_CH, 4, number of descriptor channels; ADDR_W, 32, fetch address width; LEN_W, 8, fetch length width (words).
REQ-002 Ports SHALL be (name  direction  width  meaning):
- clk  in  1  clock; reset rstb, asynchronous, active-low.
- rstb  in  1  asynchronous active-low reset.
- ch_fetch_req  in  NUM_CH  per-channel fetch request, level, held until ch_ack.
- ch_addr  in  NUM_CH*ADDR_W  per-channel fetch address, channel i at bits [i*ADDR_W +: ADDR_W].
- ch_length  in  NUM_CH*LEN_W  per-channel fetch length, packed likewise.
- ch_ack  out  NUM_CH  one-cycle completion pulse to granted channel.
- ch_enable  in  NUM_CH  channel enable mask; disabled channels are never granted.
- prio_mode  in  1  0 = round-robin, 1 = fixed priority (channel 0 highest).
- mem_req  out  1  request to shared read engine, level.
- mem_addr  out  ADDR_W  latched address of granted channel.
- mem_length  out  LEN_W  latched length of granted channel.
- mem_ch_id  out  log2(NUM_CH)  granted channel index.
- mem_ack  in  1  read engine accepted/completed current request, one-cycle pulse.
- busy  out  1  high in any state other than IDLE.
- protocol_err  out  1  sticky; mem_ack received outside BUSY.

Function
REQ-003 FSM SHALL have states IDLE, BUSY, ACK; all outputs registered.
REQ-004 IDLE: eligible = ch_fetch_req & ch_enable; if eligible != 0, next state BUSY, latch winner index, its ch_addr and ch_length, assert mem_req; else stay IDLE.
REQ-005 Latency SHALL be: eligible request sampled in cycle N -> mem_req=1 with valid mem_addr/mem_length/mem_ch_id in cycle N+1.
REQ-006 BUSY: mem_req, mem_addr, mem_length, mem_ch_id SHALL hold stable until mem_ack sampled high.
REQ-007 BUSY with mem_ack=1 in cycle K: cycle K+1 SHALL have mem_req=0, ch_ack[mem_ch_id]=1 (only that bit), state ACK.
REQ-008 ACK SHALL last exactly one cycle then go to IDLE; requests are not sampled in ACK, so a requester dropping its request the cycle after ch_ack is never re-granted.
REQ-009 Minimum spacing between consecutive grants SHALL be 3 cycles (IDLE, BUSY with same-cycle mem_ack, ACK).
REQ-010 Round-robin: search starts at index last_grant+1, wraps modulo NUM_CH; first eligible wins.
REQ-011 Fixed priority: lowest eligible index wins.
REQ-012 last_grant SHALL update to the winner on every grant in both modes; prio_mode changes take effect on the next IDLE arbitration only.
REQ-013 ch_enable or ch_fetch_req deasserting for the granted channel during BUSY SHALL NOT abort the transfer; transfer completes and ch_ack is still pulsed.
REQ-014 ch_addr/ch_length changes after latching SHALL NOT affect mem_addr/mem_length.
REQ-015 mem_ack in IDLE or ACK SHALL be ignored for FSM purposes and set protocol_err=1; protocol_err cleared only by reset.
REQ-016 eligible = 0 in IDLE: no output changes, last_grant unchanged.

Reset
REQ-017 rstb low SHALL asynchronously force: state IDLE, mem_req 0, mem_addr 0, mem_length 0, mem_ch_id 0, ch_ack 0, busy 0, protocol_err 0, last_grant NUM_CH-1 (channel 0 wins first round-robin).
REQ-018 Reset mid-transfer SHALL drop mem_req immediately with no ch_ack issued; requesters are reset by the same rstb.

Structure
REQ-019 Shared package fetch_arb_pkg SHALL hold the state encoding (IDLE=2'b00, BUSY=2'b01, ACK=2'b10) and default NUM_CH/ADDR_W/LEN_W constants.
REQ-020 Winner selection SHALL be one combinational sub-module fetch_arb_rr_pick (inputs eligible, last_grant, prio_mode; outputs winner index, found).

Verification
REQ-021 Single: ch1 req, addr 0x1000, len 8, enables 4'hF; mem_ack 2 cycles after mem_req -> mem_req next cycle, mem_ch_id 1, mem_addr 0x1000, mem_length 8; ch_ack=4'b0010 for one cycle after mem_ack.
REQ-022 Round-robin: all four channels request continuously, mem_ack each grant -> grant order 0,1,2,3,0,...; each ch_ack only to granted channel.
REQ-023 Fixed priority: prio_mode=1, ch0 and ch2 requesting continuously -> ch0 always granted, ch2 never until ch0 drops.
REQ-024 Mask: ch_enable=4'b1011, ch2 requesting alone -> mem_req stays 0; clear ch_enable[1] during ch1 BUSY -> ch1 still completes with ch_ack.
REQ-025 Error and reset: mem_ack pulse in IDLE -> protocol_err=1 sticky, no ch_ack; rstb low during BUSY -> mem_req=0 immediately, first grant after reset goes to ch0.
